// File: rtl/dmem_ctrl_pkg.sv
// Shared types and constants for the data-memory subsystem.
package rv_mem_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned MMIO_GPIO   = 0;
    localparam int unsigned MMIO_CYC_LO = 4;
    localparam int unsigned MMIO_CYC_HI = 8;

    typedef enum logic [1:0] {
        SZ_B   = 2'd0,
        SZ_H   = 2'd1,
        SZ_W   = 2'd2,
        SZ_BAD = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Captured request fields
    typedef struct packed {
        logic            we;
        size_e           size;
        logic            uns;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    // Illegal size or natural-alignment violation
    function automatic logic align_err(size_e size, logic [1:0] lsb);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return lsb[0];
            SZ_W:    return lsb != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Load/store request and response bus between the core and the data memory.
interface dmem_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_uns;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_uns, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_ctrl_mmio_regs.sv
// MMIO window: GPIO output register, free-running 64-bit cycle counter, read mux.
module mmio_regs
    import rv_mem_pkg::*;
#(
    parameter int unsigned GPIO_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [31:0]       off,
    input  logic [GPIO_W-1:0] wr_data,
    output logic [31:0]       rd_data_c,
    output logic [GPIO_W-1:0] gpio_out
);

    logic [63:0] cyc_q;

    // GPIO register; counter offsets and unmapped offsets ignore writes
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out <= '0;
        end else if (wr_en && off == 32'(MMIO_GPIO)) begin
            gpio_out <= wr_data;
        end
    end

    // Cycle counter, wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_q + 64'd1;
        end
    end

    // Register read mux; unmapped offsets read as zero
    always_comb begin
        rd_data_c = '0;
        case (off)
            32'(MMIO_GPIO):   rd_data_c = 32'(gpio_out);
            32'(MMIO_CYC_LO): rd_data_c = cyc_q[31:0];
            32'(MMIO_CYC_HI): rd_data_c = cyc_q[63:32];
            default:          rd_data_c = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data memory controller: sub-word RAM access, wait states, MMIO window.
module dmem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned LATENCY   = 2,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
    parameter int unsigned GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    dmem_ctrl_if.slave        bus,
    output logic [GPIO_W-1:0] gpio_out
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = 4;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    req_t            req_q, cur_req;
    logic [31:0]     ram [DEPTH];

    logic            ready_q, valid_q, err_q;
    logic [31:0]     rdata_q;

    logic            accept_c, err_c, is_mmio_c, commit_c;
    logic [AW-1:0]   idx_c;
    logic [31:0]     off_c, ram_word_c, load_c, mmio_rd_c, wd_c;
    logic [7:0]      lane_b_c;
    logic [15:0]     lane_h_c;
    logic [3:0]      be_c;

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    assign accept_c = ready_q && bus.req_valid;

    // Live bus fields while idle, captured fields while the request is in flight
    always_comb begin
        cur_req = req_q;
        if (state_q == IDLE) begin
            cur_req.we    = bus.req_we;
            cur_req.size  = size_e'(bus.req_size);
            cur_req.uns   = bus.req_uns;
            cur_req.addr  = bus.req_addr;
            cur_req.wdata = bus.req_wdata;
        end
    end

    // Address decode and error detection
    assign is_mmio_c = cur_req.addr >= MMIO_BASE;
    assign err_c     = align_err(cur_req.size, cur_req.addr[1:0]) ||
                       (is_mmio_c && cur_req.size != SZ_W);
    assign idx_c     = cur_req.addr[AW+1:2];
    assign off_c     = cur_req.addr - MMIO_BASE;

    // Load path: lane extraction then sign/zero extension
    assign ram_word_c = ram[idx_c];
    assign lane_b_c   = ram_word_c[{cur_req.addr[1:0], 3'b000} +: 8];
    assign lane_h_c   = ram_word_c[{cur_req.addr[1], 4'b0000} +: 16];

    always_comb begin
        load_c = '0;
        if (is_mmio_c) begin
            load_c = mmio_rd_c;
        end else begin
            case (cur_req.size)
                SZ_B:    load_c = cur_req.uns ? {24'b0, lane_b_c}
                                              : {{24{lane_b_c[7]}}, lane_b_c};
                SZ_H:    load_c = cur_req.uns ? {16'b0, lane_h_c}
                                              : {{16{lane_h_c[15]}}, lane_h_c};
                SZ_W:    load_c = ram_word_c;
                default: load_c = '0;
            endcase
        end
    end

    // Store path: replicate data across lanes, enable only the addressed bytes
    always_comb begin
        be_c = 4'b0000;
        wd_c = cur_req.wdata;
        case (cur_req.size)
            SZ_B: begin
                be_c = 4'b0001 << cur_req.addr[1:0];
                wd_c = {4{cur_req.wdata[7:0]}};
            end
            SZ_H: begin
                be_c = cur_req.addr[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{cur_req.wdata[15:0]}};
            end
            SZ_W:    be_c = 4'b1111;
            default: be_c = 4'b0000;
        endcase
    end

    // Stores commit at the end of the response cycle unless it was an error
    assign commit_c = (state_q == RESP) && !reset && cur_req.we && !err_q;

    // RAM array, not reset
    always_ff @(posedge clk) begin
        if (commit_c && !is_mmio_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    ram[idx_c][8*i +: 8] <= wd_c[8*i +: 8];
                end
            end
        end
    end

    mmio_regs #(
        .GPIO_W (GPIO_W)
    ) u_mmio (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (commit_c && is_mmio_c),
        .off       (off_c),
        .wr_data   (cur_req.wdata[GPIO_W-1:0]),
        .rd_data_c (mmio_rd_c),
        .gpio_out  (gpio_out)
    );

    // Next-state logic; errors skip the wait states
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (err_c || LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == CW'(LATENCY - 1)) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, captured request and registered response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= state_d == IDLE;
            valid_q <= state_d == RESP;
            if (accept_c) begin
                req_q <= cur_req;
            end
            if (state_d == RESP) begin
                err_q   <= err_c;
                rdata_q <= (err_c || cur_req.we) ? 32'd0 : load_c;
            end else begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, corner sequences, random ops.
module tb_dmem_ctrl;
    import rv_mem_pkg::*;

    localparam int unsigned DEPTH   = 64;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned GPIO_W  = 8;
    localparam logic [31:0] BASE    = 32'h8000_0000;

    localparam logic [1:0] B = 2'd0;
    localparam logic [1:0] H = 2'd1;
    localparam logic [1:0] W = 2'd2;
    localparam logic [1:0] X = 2'd3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [GPIO_W-1:0] gpio_out;
    int unsigned       tb_cyc = 0;

    dmem_ctrl_if bus();

    dmem_ctrl #(
        .DEPTH     (DEPTH),
        .LATENCY   (LATENCY),
        .MMIO_BASE (BASE),
        .GPIO_W    (GPIO_W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .gpio_out (gpio_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One transaction: drive at negedge, accept at posedge, wait bounded for the response
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int unsigned acc);
        @(negedge clk);
        check("ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_size  = size;
        bus.req_uns   = uns;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        @(posedge clk);
        #1;
        acc = tb_cyc;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom_range(0, 1));
        bus.req_size  = 2'($urandom_range(0, 3));
        bus.req_uns   = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        lat   = 0;
        rdata = 32'hxxxx_xxxx;
        err   = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                lat   = i;
                rdata = bus.resp_rdata;
                err   = bus.resp_err;
                break;
            end
        end
        if (lat != 0) begin
            check("ready_busy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            check("resp_pulse", 32'(bus.resp_valid), 32'd0);
        end
    endtask

    task automatic xact(input string name, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input logic chk_rd);
        logic [31:0] rd;
        logic        e;
        int          lat;
        int unsigned acc;
        do_req(we, size, uns, addr, wdata, rd, e, lat, acc);
        check({name, ".lat"}, 32'(lat), exp_err ? 32'd1 : 32'(LATENCY));
        check({name, ".err"}, 32'(e), 32'(exp_err));
        if (chk_rd) check({name, ".rdata"}, rd, exp_rd);
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        logic [7:0]  gpio;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] rd, input logic e, input logic [7:0] g);
        vec_t v;
        v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = w;
        v.rd = rd; v.err = e; v.gpio = g;
        return v;
    endfunction

    // Byte-addressed reference memory; 256 bytes aliased across the low address space
    logic [7:0] mb [256];
    logic [7:0] gpio_m;

    task automatic model(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic e, output logic chk);
        int unsigned nb;
        logic [31:0] off;
        logic [7:0]  bi;
        rd = 32'd0; e = 1'b0; chk = 1'b1;
        if (size == X) begin e = 1'b1; return; end
        nb = 1 << size;
        if (addr % nb != 0) e = 1'b1;
        if (addr >= BASE && nb != 4) e = 1'b1;
        if (e) return;
        if (addr >= BASE) begin
            off = addr - BASE;
            if (we) begin
                if (off == 32'd0) gpio_m = wdata[7:0];
            end else if (off == 32'd0) begin
                rd = {24'd0, gpio_m};
            end else if (off == 32'd4 || off == 32'd8) begin
                chk = 1'b0;
            end
            return;
        end
        for (int i = 0; i < int'(nb); i++) begin
            bi = 8'(addr + 32'(i));
            if (we) mb[bi] = wdata[8*i +: 8];
            else    rd[8*i +: 8] = mb[bi];
        end
        if (!we && !uns && rd[8*nb-1]) begin
            for (int i = int'(nb); i < 4; i++) rd[8*i +: 8] = 8'hFF;
        end
    endtask

    task automatic rand_op(input string name, input logic we, input logic [1:0] size,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] rd;
        logic        e, chk;
        model(we, size, uns, addr, wdata, rd, e, chk);
        xact(name, we, size, uns, addr, wdata, rd, e, chk);
        check({name, ".gpio"}, 32'(gpio_out), 32'(gpio_m));
    endtask

    vec_t tbl[$];

    initial begin
        logic [31:0] c1, c2, hi, a, w;
        logic        e1, e2, eh, we, uns;
        logic [1:0]  sz;
        int          l1, l2, lh;
        int unsigned acc1, acc2, acch;

        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0;
        bus.req_uns = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst.ready", 32'(bus.req_ready), 32'd1);
        check("rst.valid", 32'(bus.resp_valid), 32'd0);
        check("rst.rdata", bus.resp_rdata, 32'd0);
        check("rst.err",   32'(bus.resp_err), 32'd0);
        check("rst.gpio",  32'(gpio_out), 32'd0);
        reset = 1'b0;

        // Directed vectors
        tbl.push_back(mk(1'b1, W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, B, 1'b0, 32'h13, 32'h80, 32'h0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, B, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, B, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, W, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, H, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b1, W, 1'b0, 32'h12, 32'h55, 32'h0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, W, 1'b0, 32'h10, 32'h0, 32'h80ADBEEF, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, W, 1'b0, 32'h100, 32'h1234, 32'h0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, W, 1'b0, 32'h0, 32'h0, 32'h00001234, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, X, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b1, W, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, H, 1'b0, 32'h22, 32'hCAFE, 32'h0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, W, 1'b0, 32'h20, 32'h0, 32'hCAFE3344, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, H, 1'b1, 32'h22, 32'h0, 32'h0000CAFE, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, H, 1'b0, 32'h22, 32'h0, 32'hFFFFCAFE, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, B, 1'b0, 32'h21, 32'h0, 32'h00000033, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, B, 1'b1, 32'h23, 32'h0, 32'h000000CA, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, B, 1'b0, 32'h21, 32'h7F, 32'h0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, W, 1'b0, 32'h20, 32'h0, 32'hCAFE7F44, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, B, 1'b0, 32'h7FFF_FF13, 32'h0, 32'hFFFFFF80, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, W, 1'b0, 32'h7FFF_FFFC, 32'h0BADCAFE, 32'h0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, W, 1'b0, 32'hFC, 32'h0, 32'h0BADCAFE, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, W, 1'b0, BASE, 32'h1A5, 32'h0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, W, 1'b0, BASE, 32'h0, 32'h000000A5, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b1, W, 1'b0, BASE + 32'h4, 32'h1, 32'h0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b1, W, 1'b0, BASE + 32'h8, 32'h1, 32'h0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, W, 1'b0, BASE + 32'h10, 32'h0, 32'h0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b1, W, 1'b0, BASE + 32'h10, 32'h77, 32'h0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, B, 1'b0, BASE, 32'h0, 32'h0, 1'b1, 8'hA5));
        tbl.push_back(mk(1'b1, H, 1'b0, BASE, 32'h33, 32'h0, 1'b1, 8'hA5));
        tbl.push_back(mk(1'b0, W, 1'b0, BASE + 32'h2, 32'h0, 32'h0, 1'b1, 8'hA5));

        for (int i = 0; i < tbl.size(); i++) begin
            xact($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].uns,
                 tbl[i].addr, tbl[i].wdata, tbl[i].rd, tbl[i].err, 1'b1);
            check($sformatf("vec%0d.gpio", i), 32'(gpio_out), 32'(tbl[i].gpio));
        end

        // Cycle counter: reads N cycles apart differ by N; high word still zero
        do_req(1'b0, W, 1'b0, BASE + 32'h4, 32'h0, c1, e1, l1, acc1);
        repeat (7) @(negedge clk);
        do_req(1'b0, W, 1'b0, BASE + 32'h4, 32'h0, c2, e2, l2, acc2);
        do_req(1'b0, W, 1'b0, BASE + 32'h8, 32'h0, hi, eh, lh, acch);
        check("cyc.err", 32'({e1, e2, eh}), 32'd0);
        check("cyc.delta", c2 - c1, 32'(acc2 - acc1));
        check("cyc.hi", hi, 32'd0);

        // Reset while a store waits: dropped, no response, GPIO cleared
        xact("rst_seed", 1'b1, W, 1'b0, 32'h40, 32'h600DF00D, 32'h0, 1'b0, 1'b1);
        xact("rst_gpio", 1'b1, W, 1'b0, BASE, 32'h5A, 32'h0, 1'b0, 1'b1);
        check("rst_gpio.val", 32'(gpio_out), 32'h5A);
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = W;
        bus.req_addr = 32'h40; bus.req_wdata = 32'hBAD0BAD0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("midrst.in_wait", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst.no_resp", 32'(bus.resp_valid), 32'd0);
        end
        reset = 1'b0;
        check("midrst.gpio", 32'(gpio_out), 32'd0);
        xact("midrst.load", 1'b0, W, 1'b0, 32'h40, 32'h0, 32'h600DF00D, 1'b0, 1'b1);

        // Random operations against the byte-level model
        gpio_m = 8'h00;
        for (int i = 0; i < int'(DEPTH); i++) begin
            rand_op("fill", 1'b1, W, 1'b0, 32'(i * 4), $urandom);
        end
        for (int i = 0; i < 400; i++) begin
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz  = ($urandom_range(0, 19) == 0) ? X : 2'($urandom_range(0, 2));
            w   = $urandom;
            if ($urandom_range(0, 4) != 0) begin
                a = 32'($urandom_range(0, 32'h7FFF_FFFF));
            end else begin
                a = BASE + 32'($urandom_range(0, 5)) * 32'd4;
                if ($urandom_range(0, 9) < 7) sz = W;
            end
            if ($urandom_range(0, 9) != 0 && sz != X) begin
                a = a & ~((32'd1 << sz) - 32'd1);
            end
            rand_op($sformatf("rnd%0d", i), we, sz, uns, a, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
